// File: rtl/frame_transmitter.sv
`default_nettype none
// ============================================================================
//  Module   : frame_transmitter
//  Purpose  : Avalon-MM configured Ethernet-style frame source feeding a
//             16-bit AXI-Stream. Each frame is 4 preamble words, 3 dst-MAC
//             words, 3 src-MAC words, 1 ethertype word and N payload words
//             (tlast on the final payload word). A 32-bit payload checksum
//             uses the same arithmetic as the frame_receptor.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk                 in   1   system clock
//    reset               in   1   asynchronous active-high reset
//    writedata           in   8   Avalon write data
//    write               in   1   Avalon write strobe
//    chipselect          in   1   Avalon chip select
//    address             in   8   Avalon byte address
//    read                in   1   Avalon read strobe
//    readdata            out  8   Avalon read data (one-cycle latency)
//    egress_port_tdata   out  16  stream data
//    egress_port_tvalid  out  1   stream valid
//    egress_port_tready  in   1   stream ready
//    egress_port_tlast   out  1   last payload word of frame
// ----------------------------------------------------------------------------
//  Optional feature macro: FRAME_TX_LFSR_EN
//    defined   : payload is a 16-bit Fibonacci LFSR (taps 16,14,13,11)
//    undefined : payload increments from the seed
// ============================================================================
module frame_transmitter #(
   parameter int IFG_CYCLES = 2,
   parameter int MAX_LEN    = 1500
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  writedata,
   input  logic        write,
   input  logic        chipselect,
   input  logic [7:0]  address,
   input  logic        read,
   output logic [7:0]  readdata,
   output logic [15:0] egress_port_tdata,
   output logic        egress_port_tvalid,
   input  logic        egress_port_tready,
   output logic        egress_port_tlast
);

   localparam logic [2:0] c_st_idle     = 3'd0;
   localparam logic [2:0] c_st_preamble = 3'd1;
   localparam logic [2:0] c_st_dst      = 3'd2;
   localparam logic [2:0] c_st_src      = 3'd3;
   localparam logic [2:0] c_st_type     = 3'd4;
   localparam logic [2:0] c_st_payload  = 3'd5;
   localparam logic [2:0] c_st_gap      = 3'd6;

   localparam logic [15:0] c_max_len  = 16'(MAX_LEN);
   localparam int          c_ifg_m1   = (IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0;
   localparam logic [15:0] c_ifg_last = 16'(c_ifg_m1);

   // live configuration registers
   logic [5:0][7:0] r_dst;
   logic [5:0][7:0] r_src;
   logic [7:0]      r_type_hi;
   logic [7:0]      r_type_lo;
   logic [7:0]      r_len_lo;
   logic [7:0]      r_len_hi;
   logic [7:0]      r_seed_lo;
   logic [7:0]      r_seed_hi;
   logic            r_continuous;

   // per-frame snapshot, so config writes during a frame only affect later ones
   logic [5:0][7:0] r_sh_dst;
   logic [5:0][7:0] r_sh_src;
   logic [15:0]     r_sh_type;
   logic [15:0]     r_sh_len;

   logic [2:0]  r_state;
   logic [15:0] r_cnt;
   logic [15:0] r_gap;
   logic [15:0] r_pay;
   logic [31:0] r_csum;
   logic [7:0]  r_fcount;
   logic        r_done;
   logic [7:0]  r_readdata;

   logic        w_wr;
   logic        w_rd;
   logic        w_beat;
   logic        w_last_word;
   logic        w_last_beat;
   logic        w_start;
   logic        w_restart;
   logic        w_begin;
   logic        w_busy;
   logic [15:0] w_len_prog;
   logic [15:0] w_len_eff;
   logic [15:0] w_seed_eff;
   logic [15:0] w_pay_next;
   logic [15:0] w_tdata;
   logic [7:0]  w_rdata;

   assign w_wr   = chipselect && write;
   assign w_rd   = chipselect && read;
   assign w_busy = (r_state != c_st_idle);

   // Stream outputs are decoded from registered state only, so they cannot
   // change while a word is stalled, and an async reset drops tvalid at once.
   assign egress_port_tvalid = (r_state == c_st_preamble) || (r_state == c_st_dst) ||
                               (r_state == c_st_src) || (r_state == c_st_type) ||
                               (r_state == c_st_payload);
   assign w_last_word        = (r_state == c_st_payload) && (r_cnt == r_sh_len - 16'd1);
   assign egress_port_tlast  = w_last_word;
   assign egress_port_tdata  = w_tdata;
   assign readdata           = r_readdata;

   assign w_beat      = egress_port_tvalid && egress_port_tready;
   assign w_last_beat = w_beat && w_last_word;

   assign w_start = w_wr && (address == 8'd16) && writedata[0] && (r_state == c_st_idle);

   // Continuous restart happens at the end of the gap, or straight from the
   // tlast beat when no gap is configured.
   always_comb begin
      if (IFG_CYCLES == 0) begin
         w_restart = r_continuous && w_last_beat;
      end else begin
         w_restart = r_continuous && (r_state == c_st_gap) && (r_gap == c_ifg_last);
      end
   end

   assign w_begin = w_start || w_restart;

   assign w_len_prog = {r_len_hi, r_len_lo};
   assign w_len_eff  = (w_len_prog == 16'd0)     ? 16'd1 :
                       (w_len_prog > c_max_len)  ? c_max_len : w_len_prog;

`ifdef FRAME_TX_LFSR_EN
   assign w_seed_eff = ({r_seed_hi, r_seed_lo} == 16'd0) ? 16'hACE1 : {r_seed_hi, r_seed_lo};
   assign w_pay_next = {r_pay[0] ^ r_pay[2] ^ r_pay[3] ^ r_pay[5], r_pay[15:1]};
`else
   assign w_seed_eff = {r_seed_hi, r_seed_lo};
   assign w_pay_next = r_pay + 16'd1;
`endif

   // word presented in each state; MAC word k = {byte 2k, byte 2k+1}
   always_comb begin
      w_tdata = 16'h0000;
      case (r_state)
         c_st_preamble: w_tdata = (r_cnt == 16'd3) ? 16'h55D5 : 16'h5555;
         c_st_dst: begin
            case (r_cnt[1:0])
               2'd0:    w_tdata = {r_sh_dst[0], r_sh_dst[1]};
               2'd1:    w_tdata = {r_sh_dst[2], r_sh_dst[3]};
               default: w_tdata = {r_sh_dst[4], r_sh_dst[5]};
            endcase
         end
         c_st_src: begin
            case (r_cnt[1:0])
               2'd0:    w_tdata = {r_sh_src[0], r_sh_src[1]};
               2'd1:    w_tdata = {r_sh_src[2], r_sh_src[3]};
               default: w_tdata = {r_sh_src[4], r_sh_src[5]};
            endcase
         end
         c_st_type:    w_tdata = r_sh_type;
         c_st_payload: w_tdata = r_pay;
         default:      w_tdata = 16'h0000;
      endcase
   end

   always_comb begin
      w_rdata = 8'h00;
      for (int i = 0; i < 6; i++) begin
         if (address == 8'(i))     w_rdata = r_dst[i];
         if (address == 8'(i + 6)) w_rdata = r_src[i];
      end
      case (address)
         8'd12:   w_rdata = r_type_hi;
         8'd13:   w_rdata = r_type_lo;
         8'd14:   w_rdata = r_len_lo;
         8'd15:   w_rdata = r_len_hi;
         8'd17:   w_rdata = {6'd0, r_done, w_busy};
         8'd18:   w_rdata = r_seed_lo;
         8'd19:   w_rdata = r_seed_hi;
         8'd20:   w_rdata = r_csum[7:0];
         8'd21:   w_rdata = r_csum[15:8];
         8'd22:   w_rdata = r_csum[23:16];
         8'd23:   w_rdata = r_csum[31:24];
         8'd24:   w_rdata = r_fcount;
         default: ;
      endcase
   end

   // register file and read port
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_dst        <= '0;
         r_src        <= '0;
         r_type_hi    <= 8'h00;
         r_type_lo    <= 8'h00;
         r_len_lo     <= 8'h00;
         r_len_hi     <= 8'h00;
         r_seed_lo    <= 8'h00;
         r_seed_hi    <= 8'h00;
         r_continuous <= 1'b0;
         r_readdata   <= 8'h00;
      end else begin
         r_readdata <= w_rd ? w_rdata : 8'h00;
         if (w_wr) begin
            for (int i = 0; i < 6; i++) begin
               if (address == 8'(i))     r_dst[i] <= writedata;
               if (address == 8'(i + 6)) r_src[i] <= writedata;
            end
            case (address)
               8'd12:   r_type_hi    <= writedata;
               8'd13:   r_type_lo    <= writedata;
               8'd14:   r_len_lo     <= writedata;
               8'd15:   r_len_hi     <= writedata;
               8'd16:   r_continuous <= writedata[1];
               8'd18:   r_seed_lo    <= writedata;
               8'd19:   r_seed_hi    <= writedata;
               default: ;
            endcase
         end
      end
   end

   // frame counter and sticky done; a set in the same cycle beats the read-clear
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_fcount <= 8'h00;
         r_done   <= 1'b0;
      end else if (w_last_beat) begin
         r_fcount <= r_fcount + 8'd1;
         r_done   <= 1'b1;
      end else if (w_rd && (address == 8'd17)) begin
         r_done   <= 1'b0;
      end
   end

   // frame sequencer
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= c_st_idle;
         r_cnt     <= 16'd0;
         r_gap     <= 16'd0;
         r_pay     <= 16'd0;
         r_csum    <= 32'd0;
         r_sh_dst  <= '0;
         r_sh_src  <= '0;
         r_sh_type <= 16'd0;
         r_sh_len  <= 16'd1;
      end else if (w_begin) begin
         r_sh_dst  <= r_dst;
         r_sh_src  <= r_src;
         r_sh_type <= {r_type_hi, r_type_lo};
         r_sh_len  <= w_len_eff;
         r_pay     <= w_seed_eff;
         r_csum    <= 32'd0;
         r_cnt     <= 16'd0;
         r_gap     <= 16'd0;
         r_state   <= c_st_preamble;
      end else begin
         case (r_state)
            c_st_preamble: begin
               if (w_beat) begin
                  if (r_cnt == 16'd3) begin
                     r_cnt   <= 16'd0;
                     r_state <= c_st_dst;
                  end else begin
                     r_cnt <= r_cnt + 16'd1;
                  end
               end
            end
            c_st_dst: begin
               if (w_beat) begin
                  if (r_cnt == 16'd2) begin
                     r_cnt   <= 16'd0;
                     r_state <= c_st_src;
                  end else begin
                     r_cnt <= r_cnt + 16'd1;
                  end
               end
            end
            c_st_src: begin
               if (w_beat) begin
                  if (r_cnt == 16'd2) begin
                     r_cnt   <= 16'd0;
                     r_state <= c_st_type;
                  end else begin
                     r_cnt <= r_cnt + 16'd1;
                  end
               end
            end
            c_st_type: begin
               if (w_beat) begin
                  r_cnt   <= 16'd0;
                  r_state <= c_st_payload;
               end
            end
            c_st_payload: begin
               if (w_beat) begin
                  r_csum <= r_csum + {16'h0000, r_pay};
                  r_pay  <= w_pay_next;
                  if (w_last_word) begin
                     r_cnt   <= 16'd0;
                     r_gap   <= 16'd0;
                     r_state <= (IFG_CYCLES == 0) ? c_st_idle : c_st_gap;
                  end else begin
                     r_cnt <= r_cnt + 16'd1;
                  end
               end
            end
            c_st_gap: begin
               if (r_gap == c_ifg_last) begin
                  r_state <= c_st_idle;
               end else begin
                  r_gap <= r_gap + 16'd1;
               end
            end
            default: r_state <= c_st_idle;
         endcase
      end
   end

endmodule
`default_nettype wire
